// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IF_REQ  = 2'b00,
        IF_HOLD = 2'b01,
        IF_DROP = 2'b10
    } if_state_e;

    localparam logic [31:0] IF_NOP_INSTR = 32'hE1A0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: {pc, instruction, valid}; flush beats load, otherwise it holds.
module if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_flush,
    input  logic   i_load,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
        end else if (i_flush) begin
            r_q <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the PC, runs the req/ready handshake to instruction memory,
// parks words arriving under freeze in a skid buffer, and feeds the IF/ID register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    if_state_e   r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_addr;
    logic        r_req;
    logic [31:0] r_skid_pc, r_skid_instr;

    logic        w_resp, w_held, w_skid_load;
    logic        w_ifid_flush, w_ifid_load;
    if_id_t      w_ifid_d, w_ifid_q;

    assign w_resp = r_req &  imem_ready;
    assign w_held = r_req & ~imem_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_skid_load  = 1'b0;
        w_ifid_flush = 1'b0;
        w_ifid_load  = 1'b0;
        w_ifid_d     = '{pc: pc_inc(r_pc), instr: imem_rdata, valid: 1'b1};

        if (branch_taken) begin
            w_pc_next    = word_align(branch_addr);
            w_ifid_flush = 1'b1;
            case (r_state)
                IF_REQ:  w_state_next = w_held ? IF_DROP : IF_REQ;
                IF_DROP: w_state_next = IF_DROP;
                default: w_state_next = IF_REQ;
            endcase
        end else begin
            case (r_state)
                IF_REQ: begin
                    if (w_resp) begin
                        w_pc_next = pc_inc(r_pc);
                        if (freeze) begin
                            w_skid_load  = 1'b1;
                            w_state_next = IF_HOLD;
                        end else begin
                            w_ifid_load = 1'b1;
                        end
                    end else if (!freeze) begin
                        w_ifid_load = 1'b1;
                        w_ifid_d    = '{pc: w_ifid_q.pc, instr: NOP_INSTR, valid: 1'b0};
                    end
                end
                IF_HOLD: begin
                    if (!freeze) begin
                        w_ifid_load  = 1'b1;
                        w_ifid_d     = '{pc: r_skid_pc, instr: r_skid_instr, valid: 1'b1};
                        w_state_next = IF_REQ;
                    end
                end
                IF_DROP: begin
                    if (w_resp) w_state_next = IF_REQ;
                end
                default: w_state_next = IF_REQ;
            endcase
        end
    end

    // An outstanding request is never withdrawn or re-addressed; a new one starts
    // from the next PC whenever the next state is not parking a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IF_REQ;
            r_pc         <= RESET_PC;
            r_addr       <= RESET_PC;
            r_req        <= 1'b0;
            r_skid_pc    <= 32'd0;
            r_skid_instr <= NOP_INSTR;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_held) begin
                r_req <= 1'b1;
            end else begin
                r_req  <= (w_state_next != IF_HOLD);
                r_addr <= w_pc_next;
            end
            if (w_skid_load) begin
                r_skid_pc    <= pc_inc(r_pc);
                r_skid_instr <= imem_rdata;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_ifid_flush),
        .i_load  (w_ifid_load),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign imem_req        = r_req;
    assign imem_addr       = r_addr;
    assign pc_out          = w_ifid_q.pc;
    assign instruction_out = w_ifid_q.instr;
    assign valid_out       = w_ifid_q.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: memory handshake driven by hand, expectations hand-computed.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int errors = 0;
    int checks = 0;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc,
                              input logic [31:0] ins, input logic v);
        check({tag, ".pc_out"}, pc_out, pc);
        check({tag, ".instr"}, instruction_out, ins);
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
    endtask

    task automatic check_mem(input string tag, input logic req, input logic [31:0] addr);
        check({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        check({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        #1;
        check_ifid("reset", 32'd0, NOP, 1'b0);
        check_mem("reset", 1'b0, 32'd0);
        step(); step();
        rst = 1'b0;

        // E1: request issued one edge after reset release
        step();
        check_mem("e1", 1'b1, 32'd0);
        check_ifid("e1", 32'd0, NOP, 1'b0);

        // Zero-wait memory, four back-to-back words
        imem_ready = 1'b1; imem_rdata = 32'hA000_0000;
        step(); check_ifid("zw0", 32'h4, 32'hA000_0000, 1'b1); check_mem("zw0", 1'b1, 32'h4);
        imem_rdata = 32'hA000_0004;
        step(); check_ifid("zw1", 32'h8, 32'hA000_0004, 1'b1); check_mem("zw1", 1'b1, 32'h8);
        imem_rdata = 32'hA000_0008;
        step(); check_ifid("zw2", 32'hC, 32'hA000_0008, 1'b1); check_mem("zw2", 1'b1, 32'hC);
        imem_rdata = 32'hA000_000C;
        step(); check_ifid("zw3", 32'h10, 32'hA000_000C, 1'b1); check_mem("zw3", 1'b1, 32'h10);

        // Three wait states: address held, bubbles keep pc_out
        imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid($sformatf("wait%0d", i), 32'h10, NOP, 1'b0);
            check_mem($sformatf("wait%0d", i), 1'b1, 32'h10);
        end
        imem_ready = 1'b1; imem_rdata = 32'hA000_0010;
        step(); check_ifid("wdone", 32'h14, 32'hA000_0010, 1'b1); check_mem("wdone", 1'b1, 32'h14);

        // Freeze for three cycles; word arrives on the second
        imem_ready = 1'b0; freeze = 1'b1;
        step(); check_ifid("frz0", 32'h14, 32'hA000_0010, 1'b1); check_mem("frz0", 1'b1, 32'h14);
        imem_ready = 1'b1; imem_rdata = 32'hA000_0014;
        step(); check_ifid("frz1", 32'h14, 32'hA000_0010, 1'b1);
        check("frz1.req", {31'd0, imem_req}, 32'd0);
        imem_ready = 1'b0;
        step(); check_ifid("frz2", 32'h14, 32'hA000_0010, 1'b1);
        check("frz2.req", {31'd0, imem_req}, 32'd0);
        freeze = 1'b0;
        step(); check_ifid("unfrz", 32'h18, 32'hA000_0014, 1'b1); check_mem("unfrz", 1'b1, 32'h18);
        imem_ready = 1'b1; imem_rdata = 32'hA000_0018;
        step(); check_ifid("post0", 32'h1C, 32'hA000_0018, 1'b1);
        imem_rdata = 32'hA000_001C;
        step(); check_ifid("post1", 32'h20, 32'hA000_001C, 1'b1); check_mem("post1", 1'b1, 32'h20);

        // Branch to 0x103 (aligned to 0x100) while 0x20 is pending
        imem_ready = 1'b0;
        step(); check_mem("pend", 1'b1, 32'h20);
        branch_taken = 1'b1; branch_addr = 32'h0000_0103;
        step(); check_ifid("br", 32'd0, NOP, 1'b0); check_mem("br", 1'b1, 32'h20);
        branch_taken = 1'b0;
        step(); check_ifid("drop0", 32'd0, NOP, 1'b0); check_mem("drop0", 1'b1, 32'h20);
        imem_ready = 1'b1; imem_rdata = 32'hBAD0_0020;
        step(); check_ifid("drop1", 32'd0, NOP, 1'b0); check_mem("drop1", 1'b1, 32'h100);
        imem_rdata = 32'hA000_0100;
        step(); check_ifid("tgt", 32'h104, 32'hA000_0100, 1'b1); check_mem("tgt", 1'b1, 32'h104);

        // Freeze parks a word, then branch+freeze discards it
        freeze = 1'b1; imem_rdata = 32'hBAD0_0104;
        step(); check_ifid("hold", 32'h104, 32'hA000_0100, 1'b1);
        check("hold.req", {31'd0, imem_req}, 32'd0);
        imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h0000_0200;
        step(); check_ifid("hbr", 32'd0, NOP, 1'b0); check_mem("hbr", 1'b1, 32'h200);
        branch_taken = 1'b0; freeze = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hA000_0200;
        step(); check_ifid("hres", 32'h204, 32'hA000_0200, 1'b1);

        // Branch with same-cycle ready, then PC wrap
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC; imem_rdata = 32'hBAD0_0204;
        step(); check_ifid("wbr", 32'd0, NOP, 1'b0); check_mem("wbr", 1'b1, 32'hFFFF_FFFC);
        branch_taken = 1'b0; imem_rdata = 32'hA000_FFFC;
        step(); check_ifid("wrap", 32'h0, 32'hA000_FFFC, 1'b1); check_mem("wrap", 1'b1, 32'h0);
        imem_rdata = 32'hA000_0000;
        step(); check_mem("w4", 1'b1, 32'h4);

        // Reset in the middle of a wait state
        imem_ready = 1'b0;
        step(); check_mem("rwait", 1'b1, 32'h4);
        #2; rst = 1'b1; #1;
        check_ifid("mrst", 32'd0, NOP, 1'b0);
        check_mem("mrst", 1'b0, 32'd0);
        @(negedge clk); rst = 1'b0;
        step(); check_mem("rrel", 1'b1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage ARM pipeline; directly upstream of the decode stage.
- Owns the PC and issues requests to a variable-latency instruction memory using a req/ready handshake.
- Presents {pc_out, instruction_out, valid_out} to decode.
- Honours freeze (decode hazard) and branch redirect/flush (from EXE).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'hE1A0_0000, instruction driven when the IF/ID slot is empty (MOV r0,r0, cond AL)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
freeze  in  1  decode hazard; hold IF/ID contents and PC
branch_taken  in  1  single-cycle redirect pulse from EXE
branch_addr  in  32  redirect target; valid when branch_taken=1
imem_req  out  1  fetch request; held until imem_ready
imem_addr  out  32  fetch address; equals PC, stable while imem_req=1
imem_ready  in  1  one-cycle pulse; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
pc_out  out  32  fetched address + 4, to decode
instruction_out  out  32  instruction to decode
valid_out  out  1  IF/ID slot holds a real instruction

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC; state=REQ; imem_req=0.
  - pc_out=0; instruction_out=NOP_INSTR; valid_out=0.
  - Skid buffer empty.
  - imem_req is a registered output: it goes to 1 on the first posedge after rst deasserts.
- States:
  - REQ: request outstanding.
  - HOLD: word received while frozen, parked in skid buffer; imem_req=0.
  - DROP: outstanding response belongs to a killed path; imem_req stays 1 until ready, then the word is discarded.
- Memory handshake:
  - imem_req/imem_addr must not change while waiting for ready; a request is never withdrawn.
  - Minimum latency is ready in the same cycle as req (0 wait states). Each ready consumes exactly one request.
- REQ, on imem_ready, no branch:
  - freeze=0: IF/ID <= {PC+4, imem_rdata, valid=1}; PC <= PC+4; stay REQ (next request issued next cycle).
  - freeze=1: skid <= {PC+4, imem_rdata}; PC <= PC+4; go HOLD; IF/ID unchanged.
- REQ, no ready, no branch:
  - freeze=0: IF/ID <= {pc_out unchanged, NOP_INSTR, valid=0} (bubble).
  - freeze=1: IF/ID unchanged.
- HOLD:
  - freeze=0 (no branch): IF/ID <= skid with valid=1; skid emptied; go REQ.
  - freeze=1: remain; nothing changes.
- DROP:
  - On imem_ready: discard the word; go REQ (PC already holds the target).
  - IF/ID holds the bubble throughout.
- branch_taken=1 has the highest priority, overriding freeze:
  - PC <= branch_addr; IF/ID <= {0, NOP_INSTR, valid=0}; skid emptied.
  - Next state:
    - REQ and no imem_ready this cycle: DROP.
    - REQ with imem_ready the same cycle: REQ (that word is discarded).
    - HOLD: REQ.
    - DROP: stays DROP.
- Branch target must be word aligned; bits [1:0] are forced to 0.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- rst asserted mid-transaction abandons the request; the memory model is reset by the same rst.

Decomposition:
- defines.v gets:
  - FSM state encodings `IF_REQ, `IF_HOLD, `IF_DROP (2-bit).
  - `NOP_INSTR.
- One sub-module, if_id_reg:
  - 65-bit register {pc, instruction, valid} with load, flush and hold controls.
  - Async active-high reset to {0, NOP_INSTR, 0}.
- The FSM, PC and skid buffer remain in the top module.

Test Plan:
- Zero-wait memory, ready every cycle, no hazards, 4 words at 0,4,8,C -> valid_out=1 from cycle 2; pc_out 4,8,C,10 on consecutive cycles.
- 3-wait memory -> imem_addr stays at 0x4 for 4 cycles; valid_out=0 bubbles between fetches; instruction_out=NOP_INSTR during bubbles.
- freeze=1 for 3 cycles while a word arrives -> IF/ID holds the old instruction; state HOLD; imem_req=0; after release, the buffered word appears on the next cycle with the correct pc_out, with none lost or duplicated.
- branch_taken with branch_addr=0x100 while a request to 0x20 is pending (ready 2 cycles later) -> 0x20 data never reaches valid_out; next imem_addr=0x100; first valid pc_out=0x104.
- branch_taken and freeze asserted together in HOLD -> skid discarded; valid_out=0 next cycle; fetch resumes at the target.
- rst pulsed mid-wait-state -> all outputs at reset values immediately; after release, imem_addr=RESET_PC.
